// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x4 keypad scanner: matrix geometry, the
// legend table and the report FSM state type.
package keypad_pkg;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;
    localparam int NUM_KEYS = NUM_COLS * NUM_ROWS;

    typedef enum logic {
        IDLE = 1'b0,
        DOWN = 1'b1
    } rpt_state_e;

    // Entry [4*col + row] is the hex legend printed on that key.
    localparam logic [NUM_KEYS-1:0][3:0] LEGEND = {
        4'hD, 4'hC, 4'hB, 4'hA,
        4'hE, 4'h9, 4'h6, 4'h3,
        4'hF, 4'h8, 4'h5, 4'h2,
        4'h0, 4'h7, 4'h4, 4'h1
    };

endpackage

// File: rtl/keypad_scanner_if.sv
// Key report channel: valid/ack handshake with the key legend, plus the
// held and sticky overflow status lines.
interface keypad_if;

    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       key_held;
    logic       overflow;
    logic       overflow_clr;

    modport master (
        output key_code, key_valid, key_held, overflow,
        input  key_ack, overflow_clr
    );

    modport slave (
        input  key_code, key_valid, key_held, overflow,
        output key_ack, overflow_clr
    );

endinterface

// File: rtl/keypad_onehot_check.sv
// Classifies a 16-bit key snapshot as empty, single-key or multi-key and
// returns the bit index, which is meaningful only for a single key.
module keypad_onehot_check
    import keypad_pkg::*;
(
    input  logic [NUM_KEYS-1:0] vec_i,
    output logic                is_zero_o,
    output logic                is_single_o,
    output logic [3:0]          index_o
);

    always_comb begin
        is_zero_o   = (vec_i == '0);
        is_single_o = !is_zero_o && ((vec_i & (vec_i - 16'd1)) == '0);
        index_o     = 4'd0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (vec_i[i]) index_o = 4'(i);
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Column-strobed 4x4 keypad scanner with whole-scan debounce and a
// single-slot valid/ack key report.
//
//   state | meaning
//   IDLE  | debounced state holds no single key; next single key is a press
//   DOWN  | a press was seen; waiting for all keys to be released
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [3:0]  col_n_o,
    input  logic [3:0]  row_n_i,
    keypad_if.master    key_if
);

    localparam int             DW       = $clog2(SCAN_DIV);
    localparam logic [DW-1:0]  DW_LAST  = DW'(SCAN_DIV - 1);
    localparam logic [7:0]     CNT_MAX  = 8'(DEBOUNCE_SCANS);

    logic [3:0]          sync1_q, sync2_q;
    logic [DW-1:0]       dwell_q, dwell_d;
    logic [1:0]          col_q, col_d;
    logic [NUM_KEYS-1:0] raw_q, raw_d;
    logic [NUM_KEYS-1:0] prev_q, prev_d;
    logic [NUM_KEYS-1:0] stable_q, stable_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                upd_q, upd_d;
    rpt_state_e          state_q, state_d;
    logic [3:0]          code_q, code_d;
    logic                valid_q, valid_d;
    logic                ovf_q, ovf_d;

    logic                sample, scan_end, press;
    logic [NUM_KEYS-1:0] snap;
    logic                st_zero, st_single;
    logic [3:0]          st_index;

    keypad_onehot_check u_onehot (
        .vec_i       (stable_q),
        .is_zero_o   (st_zero),
        .is_single_o (st_single),
        .index_o     (st_index)
    );

    assign sample   = (dwell_q == DW_LAST);
    assign scan_end = sample && (col_q == 2'd3);
    // Column 3 rows join the stored columns 0-2 to form the full snapshot.
    assign snap     = {~sync2_q, raw_q[11:0]};
    assign col_n_o  = ~(4'b0001 << col_q);

    always_comb begin
        dwell_d  = dwell_q + DW'(1);
        col_d    = col_q;
        raw_d    = raw_q;
        prev_d   = prev_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        upd_d    = 1'b0;
        if (sample) begin
            dwell_d = '0;
            col_d   = col_q + 2'd1;
            raw_d[{col_q, 2'b00} +: 4] = ~sync2_q;
        end
        if (scan_end) begin
            prev_d = snap;
            if (snap == prev_q) begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + 8'd1;
            end else begin
                cnt_d = 8'd1;
            end
            if (cnt_d == CNT_MAX) begin
                stable_d = snap;
                upd_d    = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        press   = 1'b0;
        if (upd_q) begin
            case (state_q)
                IDLE: if (st_single) begin
                    state_d = DOWN;
                    press   = 1'b1;
                end
                DOWN: if (st_zero) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        code_d  = code_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (valid_q && key_if.key_ack) valid_d = 1'b0;
        // An ack in the same cycle frees the slot, so the new press is taken.
        if (press) begin
            if (!valid_q || key_if.key_ack) begin
                code_d  = LEGEND[st_index];
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
        if (key_if.overflow_clr && !(press && valid_q && !key_if.key_ack)) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 4'hF;
            sync2_q  <= 4'hF;
            dwell_q  <= '0;
            col_q    <= 2'd0;
            raw_q    <= '0;
            prev_q   <= '0;
            cnt_q    <= 8'd0;
            stable_q <= '0;
            upd_q    <= 1'b0;
            state_q  <= IDLE;
            code_q   <= 4'd0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            sync1_q  <= row_n_i;
            sync2_q  <= sync1_q;
            dwell_q  <= dwell_d;
            col_q    <= col_d;
            raw_q    <= raw_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            upd_q    <= upd_d;
            state_q  <= state_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign key_if.key_code  = code_q;
    assign key_if.key_valid = valid_q;
    assign key_if.key_held  = (state_q == DOWN) && st_single;
    assign key_if.overflow  = ovf_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad matrix model answers the
// column strobes, and expected key codes are queued when a press is driven.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [15:0] keys;
    int unsigned cyc;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  exp_code;

    keypad_if kif();

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .col_n_o (col_n),
        .row_n_i (row_n),
        .key_if  (kif)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Pressed key at [4*col+row] pulls its row low while its column is driven.
    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!col_n[c] && keys[4*c+r]) row_n[r] = 1'b0;
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        kif.key_ack = 1'b0;
        kif.overflow_clr = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (kif.key_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_unheld(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!kif.key_held) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic do_ack();
        kif.key_ack = 1'b1;
        @(negedge clk);
        kif.key_ack = 1'b0;
    endtask

    task automatic test_reset();
        bit seen;
        keys = '0;
        apply_reset();
        n_checks++; if (col_n !== 4'b1110) begin n_fail++; $display("FAIL rst_col_n got=%b want=1110", col_n); end
        n_checks++; if (kif.key_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b want=0", kif.key_valid); end
        n_checks++; if (kif.key_code !== 4'h0) begin n_fail++; $display("FAIL rst_code got=%h want=0", kif.key_code); end
        n_checks++; if (kif.key_held !== 1'b0) begin n_fail++; $display("FAIL rst_held got=%b want=0", kif.key_held); end
        n_checks++; if (kif.overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow got=%b want=0", kif.overflow); end
        release_reset();
        for (int i = 0; i < 16; i++) begin
            logic [3:0] one;
            one = 4'b0001 << (i / 4);
            n_checks++;
            if (col_n !== ~one) begin n_fail++; $display("FAIL col_seq cycle=%0d got=%b want=%b", i, col_n, ~one); end
            @(negedge clk);
        end
        seen = 1'b0;
        repeat (200) begin
            if (kif.key_valid) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL idle_no_report got=%b want=0", seen); end
    endtask

    task automatic test_hold_release();
        bit ok, seen;
        keys = 16'h0001 << 9;
        apply_reset();
        release_reset();
        exp_q.push_back(4'h6);
        repeat (48) @(negedge clk);
        n_checks++; if (kif.key_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early valid got=%b want=0", kif.key_valid); end
        @(negedge clk);
        n_checks++; if (kif.key_valid !== 1'b1) begin n_fail++; $display("FAIL latency_valid got=%b want=1", kif.key_valid); end
        exp_code = exp_q.pop_front();
        n_checks++; if (kif.key_code !== exp_code) begin n_fail++; $display("FAIL hold_code got=%h want=%h", kif.key_code, exp_code); end
        n_checks++; if (kif.key_held !== 1'b1) begin n_fail++; $display("FAIL hold_held got=%b want=1", kif.key_held); end
        repeat (40) @(negedge clk);
        n_checks++; if ({kif.key_valid, kif.key_code} !== {1'b1, exp_code}) begin
            n_fail++; $display("FAIL hold_stable got=%b/%h want=1/%h", kif.key_valid, kif.key_code, exp_code); end
        do_ack();
        n_checks++; if (kif.key_valid !== 1'b0) begin n_fail++; $display("FAIL ack_clear got=%b want=0", kif.key_valid); end
        keys = '0;
        wait_unheld(80, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL release_held got=%b want=0", kif.key_held); end
        seen = 1'b0;
        repeat (64) begin
            if (kif.key_valid) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL release_no_report got=%b want=0", seen); end
    endtask

    task automatic test_bounce();
        bit ok, seen;
        keys = '0;
        apply_reset();
        release_reset();
        seen = 1'b0;
        for (int t = 0; t < 80; t++) begin
            keys = ((t / 10) % 2 == 0) ? 16'h0001 : 16'h0000;
            if (kif.key_valid) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL bounce_no_report got=%b want=0", seen); end
        keys = 16'h0001;
        exp_q.push_back(4'h1);
        wait_valid(120, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bounce_timeout valid got=0 want=1"); end
        exp_code = exp_q.pop_front();
        n_checks++; if (kif.key_code !== exp_code) begin n_fail++; $display("FAIL bounce_code got=%h want=%h", kif.key_code, exp_code); end
        do_ack();
        seen = 1'b0;
        repeat (100) begin
            if (kif.key_valid || kif.overflow) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL bounce_single_report got=%b want=0", seen); end
        keys = '0;
    endtask

    task automatic test_multi();
        bit ok, seen;
        keys = (16'h0001 << 4) | (16'h0001 << 15);
        apply_reset();
        release_reset();
        seen = 1'b0;
        repeat (100) begin
            if (kif.key_valid || kif.key_held) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL multi_quiet got=%b want=0", seen); end
        keys = 16'h0001 << 4;
        exp_q.push_back(4'h2);
        wait_valid(100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL multi_single_timeout valid got=0 want=1"); end
        exp_code = exp_q.pop_front();
        n_checks++; if (kif.key_code !== exp_code) begin n_fail++; $display("FAIL multi_code got=%h want=%h", kif.key_code, exp_code); end
        do_ack();
        keys = keys | (16'h0001 << 15);
        repeat (80) @(negedge clk);
        n_checks++; if ({kif.key_held, kif.key_valid} !== 2'b00) begin
            n_fail++; $display("FAIL multi_in_down held/valid got=%b%b want=00", kif.key_held, kif.key_valid); end
        keys = 16'h0001 << 4;
        repeat (80) @(negedge clk);
        n_checks++; if ({kif.key_held, kif.key_valid} !== 2'b10) begin
            n_fail++; $display("FAIL multi_back_single held/valid got=%b%b want=10", kif.key_held, kif.key_valid); end
        keys = '0;
    endtask

    task automatic test_overflow();
        bit ok;
        int unsigned m;
        keys = '0;
        apply_reset();
        release_reset();
        keys = 16'h0001 << 12;
        exp_q.push_back(4'hA);
        wait_valid(100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL ovf_first_timeout valid got=0 want=1"); end
        exp_code = exp_q.pop_front();
        n_checks++; if (kif.key_code !== exp_code) begin n_fail++; $display("FAIL ovf_first_code got=%h want=%h", kif.key_code, exp_code); end
        keys = '0;
        repeat (80) @(negedge clk);
        keys = 16'h0001 << 3;
        repeat (80) @(negedge clk);
        n_checks++; if (kif.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b want=1", kif.overflow); end
        n_checks++; if ({kif.key_valid, kif.key_code} !== {1'b1, 4'hA}) begin
            n_fail++; $display("FAIL ovf_keep_code got=%b/%h want=1/a", kif.key_valid, kif.key_code); end
        kif.overflow_clr = 1'b1;
        @(negedge clk);
        kif.overflow_clr = 1'b0;
        n_checks++; if (kif.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b want=0", kif.overflow); end
        keys = '0;
        wait_unheld(80, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL ovf_release_timeout held got=1 want=0"); end
        repeat (4) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            if (cyc % 16 == 0) break;
            @(negedge clk);
        end
        m = cyc;
        keys = 16'h0001 << 10;
        exp_q.push_back(4'h9);
        while (cyc < m + 48) @(negedge clk);
        n_checks++; if ({kif.key_valid, kif.key_code} !== {1'b1, 4'hA}) begin
            n_fail++; $display("FAIL ack_press_pre got=%b/%h want=1/a", kif.key_valid, kif.key_code); end
        do_ack();
        exp_code = exp_q.pop_front();
        n_checks++; if ({kif.key_valid, kif.key_code, kif.overflow} !== {1'b1, exp_code, 1'b0}) begin
            n_fail++; $display("FAIL ack_press_same_cycle got=%b/%h/%b want=1/%h/0", kif.key_valid, kif.key_code, kif.overflow, exp_code); end
        do_ack();
        n_checks++; if (kif.key_valid !== 1'b0) begin n_fail++; $display("FAIL ack_press_drain got=%b want=0", kif.key_valid); end
        keys = '0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        keys = 16'h0001 << 5;
        apply_reset();
        release_reset();
        exp_q.push_back(4'h5);
        wait_valid(100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rmid_first_timeout valid got=0 want=1"); end
        exp_code = exp_q.pop_front();
        n_checks++; if (kif.key_code !== exp_code) begin n_fail++; $display("FAIL rmid_first_code got=%h want=%h", kif.key_code, exp_code); end
        for (int i = 0; i < 16; i++) begin
            if (cyc % 16 == 10) break;
            @(negedge clk);
        end
        n_checks++; if (col_n !== 4'b1011) begin n_fail++; $display("FAIL rmid_on_col2 got=%b want=1011", col_n); end
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        n_checks++; if ({col_n, kif.key_valid, kif.key_code, kif.key_held, kif.overflow} !== {4'b1110, 1'b0, 4'h0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL rmid_async got=%b/%b/%h/%b/%b want=1110/0/0/0/0", col_n, kif.key_valid, kif.key_code, kif.key_held, kif.overflow); end
        repeat (2) @(negedge clk);
        release_reset();
        exp_q.push_back(4'h5);
        repeat (48) @(negedge clk);
        n_checks++; if (kif.key_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_early got=%b want=0", kif.key_valid); end
        @(negedge clk);
        exp_code = exp_q.pop_front();
        n_checks++; if ({kif.key_valid, kif.key_code} !== {1'b1, exp_code}) begin
            n_fail++; $display("FAIL rmid_rereport got=%b/%h want=1/%h", kif.key_valid, kif.key_code, exp_code); end
        do_ack();
        keys = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        keys = '0;
        kif.key_ack = 1'b0;
        kif.overflow_clr = 1'b0;
        @(negedge clk);
        test_reset();
        test_hold_release();
        test_bounce();
        test_multi();
        test_overflow();
        test_reset_mid();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
